// File: rtl/mips_multicycle_ctrl.sv
// Multicycle sequencer for a small MIPS subset: owns PC/IR, fetches through an
// instruction-memory handshake, and sequences ALU, data memory and writeback.
module mips_multicycle_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [4:0]  rs_addr,
   output logic [4:0]  rt_addr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic [5:0]  alu_opcode,
   output logic [5:0]  alu_funct,
   output logic        alu_bsel,
   output logic [31:0] alu_imm,
   input  logic [31:0] alu_res,
   input  logic        alu_zero,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        instr_retired,
   output logic        illegal
);

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      ERROR
   } stateT;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_JR    = 6'b001000;

   stateT       state;
   logic [31:0] pc;
   logic [31:0] ir;
   logic        illegalQ;
   logic [31:0] dmemAddrQ;
   logic [31:0] dmemWdataQ;
   logic [31:0] rfWdataQ;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] immSext;
   logic [31:0] pcPlus4;
   logic [31:0] nextPc;
   logic        isRtype;
   logic        isJr;
   logic        isAluR;
   logic        isJal;
   logic        isSw;
   logic        isMem;
   logic        isBranchJump;
   logic        isSupported;

   assign opcode       = ir[31:26];
   assign funct        = ir[5:0];
   assign immSext      = {{16{ir[15]}}, ir[15:0]};
   assign pcPlus4      = pc + 32'd4;

   assign isRtype      = (opcode == OP_RTYPE);
   assign isJr         = isRtype && (funct == FN_JR);
   assign isAluR       = isRtype && (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT);
   assign isJal        = (opcode == OP_JAL);
   assign isSw         = (opcode == OP_SW);
   assign isMem        = (opcode == OP_LW) || isSw;
   assign isBranchJump = (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_J) || isJr;
   assign isSupported  = isAluR || isJr || isMem || isJal || (opcode == OP_J) ||
                         (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                         (opcode == OP_ADDI) || (opcode == OP_XORI);

   // Branches resolve straight from the ALU zero flag during EXEC.
   always_comb begin
      nextPc = pcPlus4;
      if (opcode == OP_BEQ) begin
         nextPc = alu_zero ? pcPlus4 + (immSext << 2) : pcPlus4;
      end else if (opcode == OP_BNE) begin
         nextPc = alu_zero ? pcPlus4 : pcPlus4 + (immSext << 2);
      end else if (opcode == OP_J || isJal) begin
         nextPc = {pcPlus4[31:28], ir[25:0], 2'b00};
      end else if (isJr) begin
         nextPc = rs_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         ir         <= '0;
         illegalQ   <= 1'b0;
         dmemAddrQ  <= '0;
         dmemWdataQ <= '0;
         rfWdataQ   <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (imem_ready) begin
                  ir    <= imem_rdata;
                  state <= DECODE;
               end
            end
            DECODE: begin
               if (isSupported) begin
                  state <= EXEC;
               end else begin
                  illegalQ <= 1'b1;
                  state    <= ERROR;
               end
            end
            EXEC: begin
               dmemAddrQ  <= rs_data + immSext;
               dmemWdataQ <= rt_data;
               rfWdataQ   <= isJal ? pcPlus4 : alu_res;
               pc         <= nextPc;
               if (isMem) begin
                  state <= MEM;
               end else if (isBranchJump) begin
                  state <= FETCH;
               end else begin
                  state <= WB;
               end
            end
            MEM: begin
               if (dmem_ready) begin
                  if (isSw) begin
                     state <= FETCH;
                  end else begin
                     rfWdataQ <= dmem_rdata;
                     state    <= WB;
                  end
               end
            end
            WB:      state <= FETCH;
            ERROR:   state <= ERROR;
            default: state <= ERROR;
         endcase
      end
   end

   // Strobes decode the current state; reset masks them so nothing fires in a reset cycle.
   assign imem_req      = !reset && (state == FETCH);
   assign dmem_req      = !reset && (state == MEM);
   assign dmem_we       = dmem_req && isSw;
   assign rf_we         = !reset && (state == WB) && (rf_waddr != 5'd0);
   assign instr_retired = !reset && (((state == EXEC) && isBranchJump) ||
                                     ((state == MEM) && dmem_ready && isSw) ||
                                     (state == WB));

   assign imem_addr  = pc;
   assign rs_addr    = ir[25:21];
   assign rt_addr    = ir[20:16];
   assign alu_opcode = (state == EXEC) ? opcode : 6'b000000;
   assign alu_funct  = (state == EXEC) ? funct : 6'b100000;
   assign alu_bsel   = isMem || (opcode == OP_ADDI) || (opcode == OP_XORI);
   assign alu_imm    = (opcode == OP_XORI) ? {16'h0000, ir[15:0]} : immSext;
   assign dmem_addr  = dmemAddrQ;
   assign dmem_wdata = dmemWdataQ;
   assign rf_waddr   = isJal ? 5'd31 : (isRtype ? ir[15:11] : ir[20:16]);
   assign rf_wdata   = rfWdataQ;
   assign illegal    = illegalQ;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a table of single-instruction vectors
// followed by hand-written error, reset and handshake sequences.
module tb_mips_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [5:0]  alu_opcode;
   logic [5:0]  alu_funct;
   logic        alu_bsel;
   logic [31:0] alu_imm;
   logic [31:0] alu_res;
   logic        alu_zero;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        instr_retired;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   mips_multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
      .alu_opcode(alu_opcode), .alu_funct(alu_funct), .alu_bsel(alu_bsel), .alu_imm(alu_imm),
      .alu_res(alu_res), .alu_zero(alu_zero),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .instr_retired(instr_retired), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rsVal;
      logic [31:0] rtVal;
      logic [31:0] aluVal;
      logic        zeroVal;
      logic [31:0] loadVal;
      int          memWait;
      int          expCycles;
      logic        expWe;
      logic [4:0]  expWaddr;
      logic [31:0] expWdata;
      logic [31:0] expPc;
      logic        expBsel;
      logic [31:0] expImm;
      int          expDmemCycles;
      logic        expDmemWe;
      logic [31:0] expDmemAddr;
      logic [31:0] expDmemWdata;
   } vecT;

   vecT vecs[14];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Runs one instruction from FETCH to retirement; unrequested readies are held high with junk data.
   task automatic applyStimulus(input vecT v, input int idx);
      int          cycles = 0;
      int          waitCnt = 0;
      int          dmemCycles = 0;
      logic        retire = 1'b0;
      logic        sawWe = 1'b0;
      logic [4:0]  waddr = '0;
      logic [31:0] wdata = '0;
      logic        dWe = 1'b0;
      logic [31:0] dAddr = '0;
      logic [31:0] dWdata = '0;
      logic        bsel = 1'b0;
      logic [31:0] imm = '0;
      logic [11:0] aluOp = '0;
      rs_data  = v.rsVal;
      rt_data  = v.rtVal;
      alu_res  = v.aluVal;
      alu_zero = v.zeroVal;
      while (cycles < 50) begin
         imem_ready = 1'b1;
         imem_rdata = imem_req ? v.instr : 32'hFC00_0000;
         if (dmem_req) begin
            dmem_ready = (waitCnt == v.memWait);
            dmem_rdata = v.loadVal;
            waitCnt++;
            dmemCycles++;
            dWe    = dmem_we;
            dAddr  = dmem_addr;
            dWdata = dmem_wdata;
         end else begin
            dmem_ready = 1'b1;
            dmem_rdata = 32'hBAD0_BAD0;
         end
         #1;
         if (cycles == 2) begin
            bsel  = alu_bsel;
            imm   = alu_imm;
            aluOp = {alu_opcode, alu_funct};
         end
         if (rf_we) begin
            sawWe = 1'b1;
            waddr = rf_waddr;
            wdata = rf_wdata;
         end
         retire = instr_retired;
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if (retire) break;
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      #1;
      checkOutput($sformatf("v%0d retired", idx), {31'd0, retire}, 32'd1);
      checkOutput($sformatf("v%0d cycles", idx), cycles, v.expCycles);
      checkOutput($sformatf("v%0d rf_we", idx), {31'd0, sawWe}, {31'd0, v.expWe});
      if (v.expWe) begin
         checkOutput($sformatf("v%0d rf_waddr", idx), {27'd0, waddr}, {27'd0, v.expWaddr});
         checkOutput($sformatf("v%0d rf_wdata", idx), wdata, v.expWdata);
      end
      checkOutput($sformatf("v%0d pc", idx), imem_addr, v.expPc);
      checkOutput($sformatf("v%0d single retire", idx), {31'd0, instr_retired}, 32'd0);
      checkOutput($sformatf("v%0d alu_bsel", idx), {31'd0, bsel}, {31'd0, v.expBsel});
      checkOutput($sformatf("v%0d alu_imm", idx), imm, v.expImm);
      checkOutput($sformatf("v%0d alu op/funct", idx), {20'd0, aluOp}, {20'd0, v.instr[31:26], v.instr[5:0]});
      if (v.expDmemCycles > 0) begin
         checkOutput($sformatf("v%0d dmem_req cycles", idx), dmemCycles, v.expDmemCycles);
         checkOutput($sformatf("v%0d dmem_we", idx), {31'd0, dWe}, {31'd0, v.expDmemWe});
         checkOutput($sformatf("v%0d dmem_addr", idx), dAddr, v.expDmemAddr);
         checkOutput($sformatf("v%0d dmem_wdata", idx), dWdata, v.expDmemWdata);
      end
   endtask

   task automatic pulseReset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("reset strobes", {27'd0, imem_req, dmem_req, rf_we, instr_retired, dmem_we}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("post-reset pc", imem_addr, 32'h0000_0000);
      checkOutput("post-reset illegal", {31'd0, illegal}, 32'd0);
      checkOutput("post-reset imem_req", {31'd0, imem_req}, 32'd1);
   endtask

   initial begin
      // instr, rs, rt, alu, zero, load, wait, cyc, we, waddr, wdata, pc, bsel, imm, dcyc, dwe, daddr, dwdata
      vecs[0]  = '{32'h2001_0005, 32'h0, 32'h0, 32'h5, 1'b0, 32'h0, 0, 4, 1'b1, 5'd1, 32'h5, 32'h04, 1'b1, 32'h5, 0, 1'b0, 32'h0, 32'h0};
      vecs[1]  = '{32'h0021_1020, 32'h5, 32'h5, 32'hA, 1'b0, 32'h0, 0, 4, 1'b1, 5'd2, 32'hA, 32'h08, 1'b0, 32'h1020, 0, 1'b0, 32'h0, 32'h0};
      vecs[2]  = '{32'h0041_1822, 32'hA, 32'h5, 32'h5, 1'b0, 32'h0, 0, 4, 1'b1, 5'd3, 32'h5, 32'h0C, 1'b0, 32'h1822, 0, 1'b0, 32'h0, 32'h0};
      vecs[3]  = '{32'h0022_202A, 32'h5, 32'hA, 32'h1, 1'b0, 32'h0, 0, 4, 1'b1, 5'd4, 32'h1, 32'h10, 1'b0, 32'h202A, 0, 1'b0, 32'h0, 32'h0};
      vecs[4]  = '{32'h1000_0003, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 0, 3, 1'b0, 5'd0, 32'h0, 32'h20, 1'b0, 32'h3, 0, 1'b0, 32'h0, 32'h0};
      vecs[5]  = '{32'h1400_0003, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 0, 3, 1'b0, 5'd0, 32'h0, 32'h24, 1'b0, 32'h3, 0, 1'b0, 32'h0, 32'h0};
      vecs[6]  = '{32'h1420_FFFE, 32'h5, 32'h0, 32'h5, 1'b0, 32'h0, 0, 3, 1'b0, 5'd0, 32'h0, 32'h20, 1'b0, 32'hFFFF_FFFE, 0, 1'b0, 32'h0, 32'h0};
      vecs[7]  = '{32'h3825_8001, 32'h5, 32'h0, 32'h8004, 1'b0, 32'h0, 0, 4, 1'b1, 5'd5, 32'h8004, 32'h24, 1'b1, 32'h0000_8001, 0, 1'b0, 32'h0, 32'h0};
      vecs[8]  = '{32'h2000_0007, 32'h0, 32'h0, 32'h7, 1'b0, 32'h0, 0, 4, 1'b0, 5'd0, 32'h0, 32'h28, 1'b1, 32'h7, 0, 1'b0, 32'h0, 32'h0};
      vecs[9]  = '{32'hAC22_FFFC, 32'h100, 32'hDEAD_BEEF, 32'hFC, 1'b0, 32'h0, 0, 4, 1'b0, 5'd0, 32'h0, 32'h2C, 1'b1, 32'hFFFF_FFFC, 1, 1'b1, 32'hFC, 32'hDEAD_BEEF};
      vecs[10] = '{32'h8C26_0008, 32'h200, 32'h0, 32'h208, 1'b0, 32'hCAFE_F00D, 3, 8, 1'b1, 5'd6, 32'hCAFE_F00D, 32'h30, 1'b1, 32'h8, 4, 1'b0, 32'h208, 32'h0};
      vecs[11] = '{32'h0800_0010, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 3, 1'b0, 5'd0, 32'h0, 32'h40, 1'b0, 32'h10, 0, 1'b0, 32'h0, 32'h0};
      vecs[12] = '{32'h0C00_0100, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 4, 1'b1, 5'd31, 32'h44, 32'h400, 1'b0, 32'h100, 0, 1'b0, 32'h0, 32'h0};
      vecs[13] = '{32'h03E0_0008, 32'h44, 32'h0, 32'h0, 1'b0, 32'h0, 0, 3, 1'b0, 5'd0, 32'h0, 32'h44, 1'b0, 32'h8, 0, 1'b0, 32'h0, 32'h0};

      reset      = 1'b1;
      imem_ready = 1'b0;
      imem_rdata = '0;
      rs_data    = '0;
      rt_data    = '0;
      alu_res    = '0;
      alu_zero   = 1'b0;
      dmem_ready = 1'b0;
      dmem_rdata = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset imem_req", {31'd0, imem_req}, 32'd0);
      checkOutput("reset illegal", {31'd0, illegal}, 32'd0);
      checkOutput("reset other strobes", {28'd0, dmem_req, dmem_we, rf_we, instr_retired}, 32'd0);
      checkOutput("reset pc", imem_addr, 32'h0);
      reset = 1'b0;
      #1;
      checkOutput("idle alu op/funct", {20'd0, alu_opcode, alu_funct}, {20'd0, 6'b000000, 6'b100000});
      checkOutput("fetch imem_req", {31'd0, imem_req}, 32'd1);

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Unsupported opcode parks the sequencer in ERROR with the PC frozen.
      imem_ready = 1'b1;
      imem_rdata = 32'hFC00_0000;
      @(posedge clk);
      @(negedge clk);
      imem_rdata = 32'h2001_0005;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #1;
         checkOutput($sformatf("error hold %0d flags", i),
                     {27'd0, illegal, imem_req, dmem_req, rf_we, instr_retired}, 32'b10000);
         checkOutput($sformatf("error hold %0d pc", i), imem_addr, 32'h44);
      end
      imem_ready = 1'b0;
      pulseReset();

      // Reset while a fetch is still waiting for ready.
      applyStimulus(vecs[0], 100);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         checkOutput($sformatf("imem wait %0d req", i), {31'd0, imem_req}, 32'd1);
         checkOutput($sformatf("imem wait %0d pc", i), imem_addr, 32'h4);
      end
      pulseReset();

      // Unsupported R-type funct is also illegal.
      imem_ready = 1'b1;
      imem_rdata = 32'h0000_0021;
      @(posedge clk);
      @(negedge clk);
      imem_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("bad funct illegal", {31'd0, illegal}, 32'd1);
      checkOutput("bad funct imem_req", {31'd0, imem_req}, 32'd0);
      pulseReset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
